// File: rtl/pcpi_issue_unit_pkg.sv
// Shared definitions for the PCPI issue unit: FSM state type, RISC-V opcode
// constants and instruction field getters.
package pcpi_issue_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WB,
        ST_TRAP,
        ST_DRAIN
    } issue_state_t;

    localparam logic [6:0] OPCODE_OP      = 7'b0110011;
    localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;
    localparam logic [6:0] FUNC7_MULDIV   = 7'b0000001;

    function automatic logic [4:0] insn_rd(input logic [31:0] insn);
        return insn[11:7];
    endfunction

    function automatic logic [2:0] insn_funct3(input logic [31:0] insn);
        return insn[14:12];
    endfunction

    function automatic logic [6:0] insn_opcode(input logic [31:0] insn);
        return insn[6:0];
    endfunction

    function automatic logic [6:0] insn_funct7(input logic [31:0] insn);
        return insn[31:25];
    endfunction

endpackage

// File: rtl/pcpi_issue_unit_if.sv
// PCPI co-processor bus. The issue unit is the master; the co-processor is the slave.
interface pcpi_issue_unit_if;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_ready;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_busy;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy
    );

endinterface

// File: rtl/pcpi_issue_unit_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// expiry in the cycle the count sits at TIMEOUT_CYCLES-1.
module pcpi_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign expired = enable && (count == LIMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/pcpi_issue_unit.sv
// PCPI initiator: issues one instruction at a time to the co-processor and
// turns the response into a register write-back or an illegal-instruction trap.
module pcpi_issue_unit
    import pcpi_issue_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_insn,
    input  logic [31:0]          req_rs1,
    input  logic [31:0]          req_rs2,
    input  logic                 flush,
    pcpi_issue_unit_if.master    pcpi,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic                 wb_we,
    output logic [4:0]           wb_rd_idx,
    output logic [31:0]          wb_data,
    output logic                 trap_valid,
    input  logic                 trap_ack,
    output logic [31:0]          trap_insn,
    output logic [CNT_WIDTH-1:0] retire_cnt,
    output logic [CNT_WIDTH-1:0] trap_cnt
);

    issue_state_t state_q, next_state;

    logic        valid_q;
    logic [31:0] insn_q, rs1_q, rs2_q;
    logic        we_q;
    logic [4:0]  idx_q;
    logic [31:0] data_q;
    logic [CNT_WIDTH-1:0] retire_q, trap_q;

    logic wd_clear, wd_enable, wd_expired;

    pcpi_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Busy cycles restart the watchdog; a flush while issuing restarts it for the drain window.
    always_comb begin
        next_state = state_q;
        wd_clear   = 1'b0;
        wd_enable  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wd_clear = 1'b1;
                if (req_valid && !flush) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_clear  = pcpi.pcpi_busy || flush;
                wd_enable = !pcpi.pcpi_busy && !flush;
                if (flush) begin
                    next_state = ST_DRAIN;
                end else if (pcpi.pcpi_ready) begin
                    next_state = ST_WB;
                end else if (wd_expired) begin
                    next_state = ST_TRAP;
                end
            end
            ST_DRAIN: begin
                wd_clear  = pcpi.pcpi_busy;
                wd_enable = !pcpi.pcpi_busy;
                if (pcpi.pcpi_ready || wd_expired) begin
                    next_state = ST_IDLE;
                end
            end
            ST_WB: begin
                if (flush || wb_ready) begin
                    next_state = ST_IDLE;
                end
            end
            ST_TRAP: begin
                if (flush || trap_ack) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q  <= 1'b0;
            insn_q   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            data_q   <= '0;
            retire_q <= '0;
            trap_q   <= '0;
        end else begin
            valid_q <= (next_state == ST_ISSUE);
            if (state_q == ST_IDLE && next_state == ST_ISSUE) begin
                insn_q <= req_insn;
                rs1_q  <= req_rs1;
                rs2_q  <= req_rs2;
            end
            if (state_q == ST_ISSUE && next_state == ST_WB) begin
                data_q <= pcpi.pcpi_rd;
                we_q   <= pcpi.pcpi_wr && (insn_rd(insn_q) != 5'd0);
                idx_q  <= insn_rd(insn_q);
            end
            // A flush abandons the offer, so it must not be counted.
            if (state_q == ST_WB && wb_ready && !flush) begin
                retire_q <= retire_q + CNT_WIDTH'(1);
            end
            if (state_q == ST_TRAP && trap_ack && !flush) begin
                trap_q <= trap_q + CNT_WIDTH'(1);
            end
        end
    end

    assign req_ready       = (state_q == ST_IDLE);
    assign pcpi.pcpi_valid = valid_q;
    assign pcpi.pcpi_insn  = insn_q;
    assign pcpi.pcpi_rs1   = rs1_q;
    assign pcpi.pcpi_rs2   = rs2_q;
    assign wb_valid        = (state_q == ST_WB);
    assign wb_we           = we_q;
    assign wb_rd_idx       = idx_q;
    assign wb_data         = data_q;
    assign trap_valid      = (state_q == ST_TRAP);
    assign trap_insn       = trap_valid ? insn_q : 32'd0;
    assign retire_cnt      = retire_q;
    assign trap_cnt        = trap_q;

endmodule

// File: tb/tb_pcpi_issue_unit.sv
// Scoreboard bench for pcpi_issue_unit: a behavioural co-processor drives the
// PCPI bus while a separate monitor pops expected outcomes on write-back/trap.
module tb_pcpi_issue_unit;
    import pcpi_issue_unit_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int CW      = 32;

    logic              clk, resetn;
    logic              req_valid, req_ready, flush;
    logic [31:0]       req_insn, req_rs1, req_rs2;
    logic              wb_valid, wb_ready, wb_we;
    logic [4:0]        wb_rd_idx;
    logic [31:0]       wb_data;
    logic              trap_valid, trap_ack;
    logic [31:0]       trap_insn;
    logic [CW-1:0]     retire_cnt, trap_cnt;

    pcpi_issue_unit_if pcpi_bus();

    pcpi_issue_unit #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_insn  (req_insn),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .flush     (flush),
        .pcpi      (pcpi_bus.master),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_we     (wb_we),
        .wb_rd_idx (wb_rd_idx),
        .wb_data   (wb_data),
        .trap_valid(trap_valid),
        .trap_ack  (trap_ack),
        .trap_insn (trap_insn),
        .retire_cnt(retire_cnt),
        .trap_cnt  (trap_cnt)
    );

    typedef struct {
        bit          is_trap;
        bit          we;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [31:0] insn;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    int          hold_len = 0;
    logic [31:0] exp_retire = 0;
    logic [31:0] exp_trap = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // RISC-V M-extension semantics, used both by the modelled co-processor and the scoreboard.
    function automatic logic [31:0] m_ext_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'd0, b});
        logic [63:0] p;
        case (f3)
            3'd0: return a * b;
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Write-back/trap sink plus scoreboard monitor.
    initial begin : monitor
        int          age;
        bit          held;
        logic [31:0] held_data;
        exp_t        e;
        age = 0;
        held = 0;
        held_data = 0;
        wb_ready = 1'b0;
        trap_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                wb_ready = 1'b0;
                trap_ack = 1'b0;
                age = 0;
                held = 0;
                exp_retire = 0;
                exp_trap = 0;
            end else begin
                if (wb_valid || trap_valid) age++;
                else age = 0;
                if (age <= hold_len) begin
                    wb_ready = 1'b0;
                    trap_ack = 1'b0;
                end else begin
                    wb_ready = ($urandom_range(0, 2) != 0);
                    trap_ack = ($urandom_range(0, 2) != 0);
                end
                if (wb_valid) begin
                    if (held) check_output("wb_data_stable", wb_data, held_data);
                    held = 1;
                    held_data = wb_data;
                end else begin
                    held = 0;
                end
                if ((wb_valid && wb_ready) || (trap_valid && trap_ack)) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_outcome", {30'd0, trap_valid, wb_valid}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("outcome_kind", {30'd0, trap_valid, wb_valid}, e.is_trap ? 32'd2 : 32'd1);
                        if (wb_valid) begin
                            check_output("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                            check_output("wb_rd_idx", {27'd0, wb_rd_idx}, {27'd0, e.idx});
                            check_output("wb_data", wb_data, e.data);
                            check_output("retire_cnt", retire_cnt, exp_retire);
                            exp_retire++;
                        end else begin
                            check_output("trap_insn", trap_insn, e.insn);
                            check_output("trap_cnt", trap_cnt, exp_trap);
                            exp_trap++;
                        end
                    end
                    held = 0;
                    age = 0;
                end
            end
        end
    end

    function automatic logic [31:0] make_insn(input logic [6:0] opcode, input logic [2:0] f3, input logic [4:0] rd);
        return {FUNC7_MULDIV, 5'd12, 5'd11, f3, rd, opcode};
    endfunction

    task automatic wait_idle();
        int guard = 0;
        while ((exp_q.size() != 0 || !req_ready) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check_output("idle_reached", {31'd0, req_ready}, 32'd1);
    endtask

    // Issues one instruction and plays the co-processor for it.
    task automatic apply_stimulus(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                                  input int latency, input int busy_pct, input bit wr,
                                  input int flush_at, input int drain_busy, input bit drain_ready);
        int   guard;
        int   run;
        int   trap_cycle;
        int   k;
        int   k2;
        bit   busy_pat[$];
        bit   b;
        exp_t e;
        guard = 0;
        while (!req_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check_output("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = rs1;
        req_rs2   = rs2;
        @(negedge clk);
        req_valid = 1'b0;
        req_insn  = $urandom;
        req_rs1   = $urandom;
        req_rs2   = $urandom;
        check_output("pcpi_valid_after_accept", {31'd0, pcpi_bus.pcpi_valid}, 32'd1);

        // Trap iff TIMEOUT consecutive idle cycles occur before the ready cycle.
        run = 0;
        trap_cycle = -1;
        for (int i = 0; i < latency; i++) begin
            b = ($urandom_range(0, 99) < busy_pct) || (flush_at >= 0);
            busy_pat.push_back(b);
            if (trap_cycle < 0) begin
                run = b ? 0 : run + 1;
                if (run == TIMEOUT) trap_cycle = i;
            end
        end
        if (flush_at < 0) begin
            e.is_trap = (trap_cycle >= 0);
            e.we      = wr && (insn[11:7] != 5'd0);
            e.idx     = insn[11:7];
            e.data    = m_ext_model(insn[14:12], rs1, rs2);
            e.insn    = insn;
            exp_q.push_back(e);
        end

        for (k = 0; k <= latency; k++) begin
            if (!pcpi_bus.pcpi_valid) begin
                check_output("issue_cycles", 32'(k), (trap_cycle >= 0) ? 32'(trap_cycle + 1) : 32'(latency));
                break;
            end
            pcpi_bus.pcpi_rd = $urandom;
            if (k == flush_at) begin
                flush = 1'b1;
                pcpi_bus.pcpi_busy = 1'b1;
            end else if (k == latency) begin
                check_output("pcpi_insn_held", pcpi_bus.pcpi_insn, insn);
                check_output("pcpi_rs1_held", pcpi_bus.pcpi_rs1, rs1);
                check_output("pcpi_rs2_held", pcpi_bus.pcpi_rs2, rs2);
                pcpi_bus.pcpi_ready = 1'b1;
                pcpi_bus.pcpi_busy  = 1'b0;
                pcpi_bus.pcpi_wr    = wr;
                pcpi_bus.pcpi_rd    = m_ext_model(pcpi_bus.pcpi_insn[14:12], pcpi_bus.pcpi_rs1, pcpi_bus.pcpi_rs2);
            end else begin
                pcpi_bus.pcpi_busy = busy_pat[k];
            end
            @(negedge clk);
            pcpi_bus.pcpi_ready = 1'b0;
            pcpi_bus.pcpi_busy  = 1'b0;
            if (k == flush_at) begin
                flush = 1'b0;
                for (k2 = 0; k2 < 400; k2++) begin
                    if (k2 == 0) check_output("drain_pcpi_valid", {31'd0, pcpi_bus.pcpi_valid}, 32'd0);
                    if (req_ready) break;
                    if (drain_ready && k2 == drain_busy) begin
                        pcpi_bus.pcpi_ready = 1'b1;
                        pcpi_bus.pcpi_busy  = 1'b0;
                        pcpi_bus.pcpi_wr    = 1'b1;
                        pcpi_bus.pcpi_rd    = $urandom;
                    end else begin
                        pcpi_bus.pcpi_busy = (k2 < drain_busy);
                    end
                    @(negedge clk);
                    pcpi_bus.pcpi_ready = 1'b0;
                end
                pcpi_bus.pcpi_busy = 1'b0;
                check_output("drain_cycles", 32'(k2),
                             drain_ready ? 32'(drain_busy + 1) : 32'(drain_busy + TIMEOUT));
                break;
            end
            if (k == latency) begin
                check_output("pcpi_valid_drop", {31'd0, pcpi_bus.pcpi_valid}, 32'd0);
                check_output("wb_valid_latency", {31'd0, wb_valid}, 32'd1);
                break;
            end
        end
    endtask

    initial begin : driver
        logic [31:0] insn;
        int          mode;
        int          fa;
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_insn  = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        flush     = 1'b0;
        pcpi_bus.pcpi_ready = 1'b0;
        pcpi_bus.pcpi_wr    = 1'b0;
        pcpi_bus.pcpi_rd    = '0;
        pcpi_bus.pcpi_busy  = 1'b0;
        #12;
        check_output("reset_pcpi_valid", {31'd0, pcpi_bus.pcpi_valid}, 32'd0);
        check_output("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_output("reset_trap_valid", {31'd0, trap_valid}, 32'd0);
        check_output("reset_retire_cnt", retire_cnt, 32'd0);
        check_output("reset_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] directed MUL / DIV / trap / busy / flush");
        apply_stimulus(32'h02C5_8533, 32'd7, 32'd6, 2, 100, 1'b1, -1, 0, 1'b0);
        wait_idle();
        hold_len = 5;
        apply_stimulus(32'h02C5_C533, 32'hFFFF_FFEC, 32'd3, 5, 100, 1'b1, -1, 0, 1'b0);
        wait_idle();
        hold_len = 0;
        apply_stimulus(32'h0000_707B, 32'd1, 32'd2, 200, 0, 1'b1, -1, 0, 1'b0);
        apply_stimulus(32'h02C5_8533, 32'd123, 32'd456, 40, 50, 1'b1, -1, 0, 1'b0);
        apply_stimulus(32'h02C5_C533, 32'd100, 32'd7, 20, 100, 1'b1, 3, 2, 1'b1);
        apply_stimulus(32'h02C5_8533, 32'd9, 32'd9, 1, 100, 1'b1, -1, 0, 1'b0);
        apply_stimulus(32'h02C5_C533, 32'd5, 32'd5, 20, 100, 1'b1, 1, 3, 1'b0);
        apply_stimulus(32'h02C5_8033, 32'd3, 32'd4, 0, 0, 1'b1, -1, 0, 1'b0);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            insn = make_insn(($urandom_range(0, 3) == 0) ? OPCODE_CUSTOM3 : OPCODE_OP,
                             3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            mode = $urandom_range(0, 9);
            if (mode < 6) begin
                apply_stimulus(insn, $urandom, $urandom, $urandom_range(0, 24), $urandom_range(0, 100),
                               ($urandom_range(0, 9) != 0), -1, 0, 1'b0);
            end else if (mode == 6) begin
                apply_stimulus(insn, $urandom, $urandom, 60, 0, 1'b1, -1, 0, 1'b0);
            end else begin
                fa = $urandom_range(0, 4);
                apply_stimulus(insn, $urandom, $urandom, fa + 8, 100, 1'b1, fa,
                               $urandom_range(0, 4), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] reset during ISSUE");
        wait_idle();
        req_valid = 1'b1;
        req_insn  = 32'h02C5_8533;
        req_rs1   = 32'd11;
        req_rs2   = 32'd13;
        @(negedge clk);
        req_valid = 1'b0;
        pcpi_bus.pcpi_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check_output("async_reset_pcpi_valid", {31'd0, pcpi_bus.pcpi_valid}, 32'd0);
        check_output("async_reset_pcpi_insn", pcpi_bus.pcpi_insn, 32'd0);
        check_output("async_reset_pcpi_rs1", pcpi_bus.pcpi_rs1, 32'd0);
        check_output("async_reset_wb_data", wb_data, 32'd0);
        check_output("async_reset_retire_cnt", retire_cnt, 32'd0);
        check_output("async_reset_trap_cnt", trap_cnt, 32'd0);
        pcpi_bus.pcpi_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        apply_stimulus(32'h02C5_8533, 32'd7, 32'd6, 3, 100, 1'b1, -1, 0, 1'b0);
        apply_stimulus(32'h0000_707B, 32'd0, 32'd0, 100, 0, 1'b1, -1, 0, 1'b0);

        wait_idle();
        repeat (2) @(negedge clk);
        check_output("final_retire_cnt", retire_cnt, exp_retire);
        check_output("final_trap_cnt", trap_cnt, exp_trap);
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
